seq_monitor: RTL and testbench

//  - Downstream checker for the 4-bit arbitrary-sequence counter output.
//  - Legal cycle: 0000 -> 1000 -> 0101 -> 1101 -> 0111 -> 0000.
//  - Samples count_in on each valid strobe and locks onto that cycle.
//  - Flags any departure from the cycle and counts completed laps.
//  - Drives status to debug LEDs and to the top-level self-check logic.

---
 rtl/seq_monitor.sv | 150 +++++++++++++++
 tb/tb_seq_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_monitor.sv
// ---------------------------------------------------------------------------
// seq_monitor
//   Downstream checker for a 4-bit arbitrary-sequence counter. It locks onto
//   the legal cycle 0000 -> 1000 -> 0101 -> 1101 -> 0111 -> 0000. While locked
//   it flags any departure with a one-cycle err pulse and counts completed
//   laps (one lap per accepted 0111 sample).
//
//   Optional feature macro: SEQ_MON_ERRCNT_EN
//     When defined, adds err_cnt[7:0]. It counts err pulses and saturates
//     at 8'hFF.
//
// Parameters
//   LOCK_N  consecutive correct transitions in SYNC needed to lock (1..15)
//   LAP_W   width of the laps counter
//
// Ports
//   clk       in   system clock, posedge
//   rst       in   asynchronous active-low reset
//   count_in  in   [3:0] counter value under test
//   valid     in   sample strobe; count_in is only evaluated when high
//   locked    out  tracking the legal cycle
//   err       out  one-cycle pulse on a mismatch while locked
//   expected  out  [3:0] next legal value the monitor expects
//   laps      out  [LAP_W-1:0] laps completed while locked (wraps)
//   err_cnt   out  [7:0] saturating err pulse count (SEQ_MON_ERRCNT_EN only)
// ---------------------------------------------------------------------------
module seq_monitor #(
    parameter int LOCK_N = 2,
    parameter int LAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       count_in,
    input  logic             valid,
    output logic             locked,
    output logic             err,
    output logic [3:0]       expected,
    output logic [LAP_W-1:0] laps
`ifdef SEQ_MON_ERRCNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t     state;
    logic [3:0] match_cnt;
    logic [4:0] match_inc;
    logic       in_set;
    logic       hit;
    logic [3:0] succ;

    function automatic logic is_legal(input logic [3:0] v);
        return (v == 4'b0000) || (v == 4'b1000) || (v == 4'b0101) ||
               (v == 4'b1101) || (v == 4'b0111);
    endfunction

    // Successor in the legal cycle. Illegal codes map to 0000 but are never
    // loaded, because every caller checks is_legal first.
    function automatic logic [3:0] nxt(input logic [3:0] v);
        logic [3:0] r;
        r = 4'b0000;
        case (v)
            4'b0000: r = 4'b1000;
            4'b1000: r = 4'b0101;
            4'b0101: r = 4'b1101;
            4'b1101: r = 4'b0111;
            4'b0111: r = 4'b0000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    assign in_set    = is_legal(count_in);
    assign hit       = (count_in == expected);
    assign succ      = nxt(count_in);
    assign match_inc = {1'b0, match_cnt} + 5'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            err       <= 1'b0;
            expected  <= 4'b0000;
            laps      <= '0;
            match_cnt <= 4'd0;
        end else begin
            // err is a pulse. Only the LOCKED-mismatch branch raises it.
            err <= 1'b0;
            if (valid) begin
                case (state)
                    HUNT: begin
                        if (in_set) begin
                            state     <= SYNC;
                            expected  <= succ;
                            match_cnt <= 4'd0;
                        end
                    end
                    SYNC: begin
                        if (hit) begin
                            expected  <= succ;
                            match_cnt <= match_inc[3:0];
                            if (match_inc == 5'(LOCK_N)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else if (in_set) begin
                            // Re-seed from the new legal value.
                            expected  <= succ;
                            match_cnt <= 4'd0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            expected <= succ;
                            if (count_in == 4'b0111)
                                laps <= laps + {{(LAP_W-1){1'b0}}, 1'b1};
                        end else begin
                            // locked falls on the same edge that err rises.
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= 4'd0;
                            if (in_set) begin
                                state    <= SYNC;
                                expected <= succ;
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

`ifdef SEQ_MON_ERRCNT_EN
    // Counts on the same edge that err is raised, so err_cnt and err agree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_cnt <= 8'h00;
        else if (valid && state == LOCKED && !hit && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'h01;
    end
`endif

endmodule

// File: tb/tb_seq_monitor.sv
module tb_seq_monitor;

    localparam int LOCK_N = 2;
    localparam int LAP_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [3:0]       count_in = 4'd0;
    logic             valid = 1'b0;
    logic             locked;
    logic             err;
    logic [3:0]       expected;
    logic [LAP_W-1:0] laps;
`ifdef SEQ_MON_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    seq_monitor #(.LOCK_N(LOCK_N), .LAP_W(LAP_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_in (count_in),
        .valid    (valid),
        .locked   (locked),
        .err      (err),
        .expected (expected),
        .laps     (laps)
`ifdef SEQ_MON_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: position in the cycle (-1 = hunting) plus a streak count.
    int seq [5] = '{0, 8, 5, 13, 7};
    int m_pos, m_streak, m_laps, m_errcnt, m_exp;
    bit m_locked, m_err;

    function automatic int idx(input int v);
        for (int i = 0; i < 5; i++) if (seq[i] == v) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pos = -1; m_streak = 0; m_laps = 0; m_errcnt = 0;
        m_exp = 0; m_locked = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input int c);
        m_err = 0;
        if (!v) return;
        if (m_pos < 0) begin
            m_pos = idx(c);
            m_streak = 0;
            if (m_pos >= 0) m_exp = seq[(m_pos + 1) % 5];
        end else if (c == m_exp) begin
            if (m_locked) begin
                if (c == 7) m_laps = (m_laps + 1) % (1 << LAP_W);
            end else begin
                m_streak++;
                if (m_streak == LOCK_N) m_locked = 1;
            end
            m_pos = (m_pos + 1) % 5;
            m_exp = seq[(m_pos + 1) % 5];
        end else begin
            if (m_locked) begin
                m_err = 1;
                m_locked = 0;
                if (m_errcnt < 255) m_errcnt++;
            end
            m_pos = idx(c);
            m_streak = 0;
            if (m_pos >= 0) m_exp = seq[(m_pos + 1) % 5];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".locked"},   32'(locked),   32'(m_locked));
        chk({tag, ".err"},      32'(err),      32'(m_err));
        chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
        chk({tag, ".laps"},     32'(laps),     32'(m_laps));
`ifdef SEQ_MON_ERRCNT_EN
        chk({tag, ".err_cnt"},  32'(err_cnt),  32'(m_errcnt));
`endif
    endtask

    // Drive one sample, let it be taken on the next posedge, check 1 ns later.
    task automatic step(input bit v, input int c, input string tag);
        valid    = v;
        count_in = 4'(c);
        @(posedge clk);
        model_step(v, c);
        #1;
        chk_all(tag);
    endtask

    initial begin
        int gcur, prev, c, r, r2;
        bit v;

        // Reset state
        model_reset();
        #12;
        chk_all("reset");
        rst = 1'b1;
        @(negedge clk);

        // Lock: 0000, 1000, 0101
        step(1, 0, "lock0");
        step(1, 8, "lock1");
        step(1, 5, "lock2");
        chk("lock.locked", 32'(locked), 32'd1);
        chk("lock.expected", 32'(expected), 32'd13);

        // Three full laps while locked
        for (int l = 0; l < 3; l++)
            for (int k = 0; k < 5; k++) step(1, seq[(k + 3) % 5], "laps");
        chk("laps3", 32'(laps), 32'd3);

        // Mismatch while locked, expected 1101 but 0111 driven
        step(1, 7, "err");
        chk("err.pulse", 32'(err), 32'd1);
        chk("err.locked", 32'(locked), 32'd0);
        chk("err.expected", 32'(expected), 32'd0);
        step(0, 0, "err_clear");
        chk("err.oneshot", 32'(err), 32'd0);

        // Illegal value drops to HUNT and stays there
        step(1, 3, "hunt0");
        step(1, 3, "hunt1");
        chk("hunt.locked", 32'(locked), 32'd0);

        // Relock, then stall valid for 5 cycles
        step(1, 0, "relock0");
        step(1, 8, "relock1");
        step(1, 5, "relock2");
        for (int i = 0; i < 5; i++) step(0, $urandom_range(0, 15), "stall");
        chk("stall.locked", 32'(locked), 32'd1);
        chk("stall.expected", 32'(expected), 32'd13);

        // Repeated value with valid=1 is a mismatch
        step(1, 13, "rep0");
        step(1, 13, "rep1");
        chk("rep.err", 32'(err), 32'd1);

        // Randomized stream: mostly legal progression, some repeats, junk, gaps
        gcur = 0; prev = 0;
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            v  = (r < 85);
            if (r2 < 80) begin
                gcur = (gcur + 1) % 5;
                c = seq[gcur];
            end else if (r2 < 90) begin
                c = prev;
            end else begin
                c = $urandom_range(0, 15);
                if (idx(c) >= 0) gcur = idx(c);
            end
            if (v) prev = c;
            step(v, c, "rand");
        end

        // Asynchronous reset mid-stream takes effect between edges
        step(1, 0, "pre_rst0");
        step(1, 8, "pre_rst1");
        step(1, 5, "pre_rst2");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("rst.locked", 32'(locked), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.laps", 32'(laps), 32'd0);
        chk("rst.expected", 32'(expected), 32'd0);
        #3 rst = 1'b1;

`ifdef SEQ_MON_ERRCNT_EN
        // 300 forced errors: the counter saturates
        step(1, 0, "ec_seed0");
        step(1, 8, "ec_seed1");
        step(1, 5, "ec_seed2");
        for (int i = 0; i < 300; i++) begin
            step(1, 0, "ec_err");
            step(1, 8, "ec_m1");
            step(1, 5, "ec_m2");
        end
        chk("errcnt.sat", 32'(err_cnt), 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
